// File: rtl/axi_burst_reader_if.sv
// AXI4 read master + AXI-Stream command/status/data bundle
// for the burst reader.
interface axi_burst_reader_if #(
  parameter int AXI_DWIDTH  = 128,
  parameter int AXI_AWIDTH  = 32,
  parameter int AXI_IDWIDTH = 1,
  parameter int LEN_WIDTH   = 16
);
  logic [AXI_IDWIDTH-1:0]          m_axi_arid;
  logic [AXI_AWIDTH-1:0]           m_axi_araddr;
  logic [7:0]                      m_axi_arlen;
  logic [2:0]                      m_axi_arsize;
  logic [1:0]                      m_axi_arburst;
  logic                            m_axi_arlock;
  logic [3:0]                      m_axi_arcache;
  logic [2:0]                      m_axi_arprot;
  logic [3:0]                      m_axi_arregion;
  logic [3:0]                      m_axi_arqos;
  logic                            m_axi_arvalid;
  logic                            m_axi_arready;
  logic [AXI_IDWIDTH-1:0]          m_axi_rid;
  logic [AXI_DWIDTH-1:0]           m_axi_rdata;
  logic [1:0]                      m_axi_rresp;
  logic                            m_axi_rlast;
  logic                            m_axi_rvalid;
  logic                            m_axi_rready;
  logic                            s_axis_cmd_tvalid;
  logic                            s_axis_cmd_tready;
  logic [LEN_WIDTH+AXI_AWIDTH-1:0] s_axis_cmd_tdata;
  logic                            m_axis_status_tvalid;
  logic                            m_axis_status_tready;
  logic [LEN_WIDTH+1:0]            m_axis_status_tdata;
  logic [AXI_DWIDTH-1:0]           m_axis_data_tdata;
  logic [AXI_DWIDTH/8-1:0]         m_axis_data_tkeep;
  logic                            m_axis_data_tlast;
  logic                            m_axis_data_tvalid;
  logic                            m_axis_data_tready;

  modport master (
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
    output m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot,
    output m_axi_arregion, m_axi_arqos, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
    input  m_axi_rvalid,
    output m_axi_rready,
    input  s_axis_cmd_tvalid, s_axis_cmd_tdata,
    output s_axis_cmd_tready,
    output m_axis_status_tvalid, m_axis_status_tdata,
    input  m_axis_status_tready,
    output m_axis_data_tdata, m_axis_data_tkeep, m_axis_data_tlast,
    output m_axis_data_tvalid,
    input  m_axis_data_tready
  );

  modport slave (
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
    input  m_axi_arburst, m_axi_arlock, m_axi_arcache, m_axi_arprot,
    input  m_axi_arregion, m_axi_arqos, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast,
    output m_axi_rvalid,
    input  m_axi_rready,
    output s_axis_cmd_tvalid, s_axis_cmd_tdata,
    input  s_axis_cmd_tready,
    input  m_axis_status_tvalid, m_axis_status_tdata,
    output m_axis_status_tready,
    input  m_axis_data_tdata, m_axis_data_tkeep, m_axis_data_tlast,
    input  m_axis_data_tvalid,
    output m_axis_data_tready
  );
endinterface

// File: rtl/axi_burst_reader.sv
// Splits a {len, addr} command into 4KB-safe AXI4 INCR
// read bursts and streams the returned beats out.
module axi_burst_reader #(
  parameter int AXI_DWIDTH      = 128,
  parameter int AXI_AWIDTH      = 32,
  parameter int AXI_IDWIDTH     = 1,
  parameter int LEN_WIDTH       = 16,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic clk,
  input logic rst,
  axi_burst_reader_if.master bus
);
  localparam int BPB = AXI_DWIDTH / 8;
  localparam int SZ  = $clog2(BPB);
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW  = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;
  localparam logic [AXI_AWIDTH-1:0] AMASK = ~AXI_AWIDTH'(BPB - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DRAIN, STATUS} state_t;

  state_t                r_state, w_next;
  logic [LEN_WIDTH-1:0]  r_len, r_remain, r_rcv;
  logic [AXI_AWIDTH-1:0] r_addr;
  logic [1:0]            r_worst;
  logic [OW-1:0]         r_outst;

  logic [LEN_WIDTH-1:0]  w_cmd_len;
  logic [AXI_AWIDTH-1:0] w_cmd_addr;
  logic [12:0]           w_bnd;
  logic [CW-1:0]         w_bnd_beats, w_cap, w_beats;
  logic w_cmd_rdy, w_cmd_hs, w_arvalid, w_ar_hs;
  logic w_active, w_r_hs, w_rlast_hs, w_last_beat, w_final;
  logic w_unused;

  assign w_cmd_len  = bus.s_axis_cmd_tdata[LEN_WIDTH+AXI_AWIDTH-1 -: LEN_WIDTH];
  assign w_cmd_addr = bus.s_axis_cmd_tdata[AXI_AWIDTH-1:0] & AMASK;
  assign w_cmd_rdy  = (r_state == IDLE) && !rst;
  assign w_cmd_hs   = bus.s_axis_cmd_tvalid && w_cmd_rdy;

  // beats left before the next 4KB page, capped by burst and remaining
  assign w_bnd       = 13'd4096 - {1'b0, r_addr[11:0]};
  assign w_bnd_beats = CW'(w_bnd >> SZ);
  assign w_cap       = (w_bnd_beats < CW'(MAX_BURST)) ? w_bnd_beats : CW'(MAX_BURST);
  assign w_beats     = (CW'(r_remain) < w_cap) ? CW'(r_remain) : w_cap;

  assign w_arvalid = (r_state == ADDR) && (r_outst != OW'(MAX_OUTSTANDING));
  assign w_ar_hs   = w_arvalid && bus.m_axi_arready;

  assign w_active    = (r_state == ADDR) || (r_state == DRAIN);
  assign w_r_hs      = w_active && bus.m_axi_rvalid && bus.m_axis_data_tready;
  assign w_rlast_hs  = w_r_hs && bus.m_axi_rlast;
  assign w_last_beat = (r_rcv + LEN_WIDTH'(1)) == r_len;
  assign w_final     = w_r_hs && w_last_beat;

  assign bus.m_axi_arid     = '0;
  assign bus.m_axi_araddr   = r_addr;
  assign bus.m_axi_arlen    = 8'(w_beats - CW'(1));
  assign bus.m_axi_arsize   = 3'(SZ);
  assign bus.m_axi_arburst  = 2'b01;
  assign bus.m_axi_arlock   = 1'b0;
  assign bus.m_axi_arcache  = 4'd0;
  assign bus.m_axi_arprot   = 3'd0;
  assign bus.m_axi_arregion = 4'd0;
  assign bus.m_axi_arqos    = 4'd0;
  assign bus.m_axi_arvalid  = w_arvalid;
  assign bus.m_axi_rready   = w_active && bus.m_axis_data_tready;

  assign bus.s_axis_cmd_tready    = w_cmd_rdy;
  assign bus.m_axis_status_tvalid = (r_state == STATUS);
  assign bus.m_axis_status_tdata  = {r_worst, r_rcv};

  assign bus.m_axis_data_tdata  = bus.m_axi_rdata;
  assign bus.m_axis_data_tkeep  = '1;
  assign bus.m_axis_data_tvalid = w_active && bus.m_axi_rvalid;
  assign bus.m_axis_data_tlast  = w_active && bus.m_axi_rvalid && w_last_beat;

  assign w_unused = ^{bus.m_axi_rid};

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (w_cmd_hs) w_next = (w_cmd_len == '0) ? STATUS : ADDR;
      ADDR:
        if (w_ar_hs && (r_remain == LEN_WIDTH'(w_beats))) w_next = DRAIN;
      DRAIN:
        if (w_final) w_next = STATUS;
      STATUS:
        if (bus.m_axis_status_tready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // command, address, beat and response tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len    <= '0;
      r_remain <= '0;
      r_rcv    <= '0;
      r_addr   <= '0;
      r_worst  <= '0;
      r_outst  <= '0;
    end else begin
      if (w_cmd_hs) begin
        r_len    <= w_cmd_len;
        r_remain <= w_cmd_len;
        r_addr   <= w_cmd_addr;
        r_rcv    <= '0;
        r_worst  <= '0;
      end
      if (w_ar_hs) begin
        r_addr   <= r_addr + (AXI_AWIDTH'(w_beats) << SZ);
        r_remain <= r_remain - LEN_WIDTH'(w_beats);
      end
      if (w_r_hs) begin
        r_rcv <= r_rcv + LEN_WIDTH'(1);
        if (bus.m_axi_rresp > r_worst) r_worst <= bus.m_axi_rresp;
      end
      if (w_ar_hs && !w_rlast_hs)      r_outst <= r_outst + OW'(1);
      else if (!w_ar_hs && w_rlast_hs) r_outst <= r_outst - OW'(1);
    end
  end
endmodule

// File: tb/tb_axi_burst_reader.sv
// Directed bench for axi_burst_reader with a small
// AXI read slave model driven cycle by cycle.
module tb_axi_burst_reader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_burst_reader_if bus ();

  axi_burst_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int fails  = 0;

  logic [31:0] ar_a[$];
  logic [7:0]  ar_l[$];
  logic [31:0] q_a[$];
  logic [7:0]  q_l[$];
  int          n_beats, n_last, ar_at_hold, ar_at_rlast;
  logic        stall_av;
  logic [17:0] st;
  bit          done, aborted;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pat(input logic [31:0] a);
    return {a ^ 32'h1111_1111, a ^ 32'h2222_2222,
            a ^ 32'h3333_3333, a ^ 32'h4444_4444};
  endfunction

  task automatic idle_inputs();
    bus.s_axis_cmd_tvalid    = 1'b0;
    bus.s_axis_cmd_tdata     = '0;
    bus.m_axi_arready        = 1'b0;
    bus.m_axi_rid            = '0;
    bus.m_axi_rdata          = '0;
    bus.m_axi_rresp          = 2'd0;
    bus.m_axi_rlast          = 1'b0;
    bus.m_axi_rvalid         = 1'b0;
    bus.m_axis_status_tready = 1'b0;
    bus.m_axis_data_tready   = 1'b0;
  endtask

  task automatic run_cmd(input logic [31:0] a, input int unsigned n,
                         input int err_at, input int hold,
                         input bit rnd, input int rst_at);
    int bpos;
    bit sent;
    logic [31:0] baddr;
    logic [127:0] exp_d;
    ar_a.delete(); ar_l.delete(); q_a.delete(); q_l.delete();
    n_beats = 0; n_last = 0; ar_at_hold = -1; ar_at_rlast = -1;
    stall_av = 1'bx; st = 'x; done = 0; aborted = 0;
    bpos = 0; sent = 0; exp_d = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == hold) ar_at_hold = ar_a.size();
      bus.s_axis_cmd_tvalid    = !sent;
      bus.s_axis_cmd_tdata     = {n[15:0], a};
      bus.m_axi_arready        = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.m_axis_data_tready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.m_axis_status_tready = 1'b1;
      if (q_a.size() > 0 && cyc >= hold) begin
        baddr = q_a[0] + 32'(bpos * 16);
        exp_d = pat(baddr);
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rdata  = exp_d;
        bus.m_axi_rlast  = (bpos == int'(q_l[0]));
        bus.m_axi_rresp  = (n_beats + 1 == err_at) ? 2'd2 : 2'd0;
      end else begin
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
        bus.m_axi_rresp  = 2'd0;
      end
      #1;
      if (cyc == hold - 1) stall_av = bus.m_axi_arvalid;
      if (!sent && bus.s_axis_cmd_tready) sent = 1;
      if (bus.m_axi_arvalid && bus.m_axi_arready) begin
        ar_a.push_back(bus.m_axi_araddr); ar_l.push_back(bus.m_axi_arlen);
        q_a.push_back(bus.m_axi_araddr);  q_l.push_back(bus.m_axi_arlen);
      end
      if (bus.m_axi_rvalid && bus.m_axi_rready) begin
        n_beats++;
        chk("tdata", bus.m_axis_data_tdata, exp_d);
        chk("tlast", bus.m_axis_data_tlast, n_beats == int'(n));
        if (bus.m_axis_data_tlast) n_last++;
        if (bus.m_axi_rlast) begin
          if (ar_at_rlast < 0) ar_at_rlast = ar_a.size();
          void'(q_a.pop_front()); void'(q_l.pop_front());
          bpos = 0;
        end else bpos++;
      end
      if (bus.m_axis_status_tvalid && bus.m_axis_status_tready) begin
        st = bus.m_axis_status_tdata;
        done = 1;
        break;
      end
      if (rst_at > 0 && n_beats >= rst_at) begin
        aborted = 1;
        break;
      end
    end
    chk("finished", done | aborted, 1'b1);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("rst_cmd_rdy0", bus.s_axis_cmd_tready, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_arvalid", bus.m_axi_arvalid, 1'b0);
    chk("rst_stat_v", bus.m_axis_status_tvalid, 1'b0);
    chk("rst_cmd_rdy", bus.s_axis_cmd_tready, 1'b0);
    rst = 1'b0;
    #1;
    chk("rel_cmd_rdy", bus.s_axis_cmd_tready, 1'b1);

    // 40 beats from 0x1000: bursts of 16,16,8
    run_cmd(32'h1000, 40, 0, 0, 0, 0);
    chk("t1_nar", ar_a.size(), 3);
    chk("t1_a0", ar_a[0], 32'h1000); chk("t1_l0", ar_l[0], 15);
    chk("t1_a1", ar_a[1], 32'h1100); chk("t1_l1", ar_l[1], 15);
    chk("t1_a2", ar_a[2], 32'h1200); chk("t1_l2", ar_l[2], 7);
    chk("t1_beats", n_beats, 40);
    chk("t1_nlast", n_last, 1);
    chk("t1_status", st, 18'h00028);

    // 4KB split: 0x0FC0 len 8 -> 4 + 4 beats
    run_cmd(32'h0FC0, 8, 0, 0, 0, 0);
    chk("t2_nar", ar_a.size(), 2);
    chk("t2_a0", ar_a[0], 32'h0FC0); chk("t2_l0", ar_l[0], 3);
    chk("t2_a1", ar_a[1], 32'h1000); chk("t2_l1", ar_l[1], 3);
    chk("t2_status", st, 18'h00008);

    // unaligned start is forced down to a beat boundary
    run_cmd(32'h2008, 2, 0, 0, 0, 0);
    chk("t2u_a0", ar_a[0], 32'h2000); chk("t2u_l0", ar_l[0], 1);
    chk("t2u_status", st, 18'h00002);

    // outstanding limit: R withheld for 12 cycles
    run_cmd(32'h2000, 100, 0, 12, 0, 0);
    chk("t3_ar_hold", ar_at_hold, 4);
    chk("t3_stall_av", stall_av, 1'b0);
    chk("t3_ar_rlast", ar_at_rlast, 4);
    chk("t3_nar", ar_a.size(), 7);
    chk("t3_llast", ar_l[6], 3);
    chk("t3_beats", n_beats, 100);
    chk("t3_nlast", n_last, 1);
    chk("t3_status", st, 18'h00064);

    // SLVERR on beat 5, random backpressure
    run_cmd(32'h4000, 16, 5, 0, 1, 0);
    chk("t4_nar", ar_a.size(), 1);
    chk("t4_a0", ar_a[0], 32'h4000); chk("t4_l0", ar_l[0], 15);
    chk("t4_beats", n_beats, 16);
    chk("t4_status", st, 18'h20010);

    // zero-length command, status held under backpressure
    @(negedge clk);
    idle_inputs();
    bus.s_axis_cmd_tvalid = 1'b1;
    bus.s_axis_cmd_tdata  = {16'd0, 32'h7000};
    #1;
    chk("t5_cmd_rdy", bus.s_axis_cmd_tready, 1'b1);
    @(negedge clk);
    bus.s_axis_cmd_tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_stat_v", bus.m_axis_status_tvalid, 1'b1);
      chk("t5_stat_d", bus.m_axis_status_tdata, 18'h0);
      chk("t5_cmd_rdy0", bus.s_axis_cmd_tready, 1'b0);
      chk("t5_arvalid", bus.m_axi_arvalid, 1'b0);
      @(negedge clk);
    end
    bus.m_axis_status_tready = 1'b1;
    #1;
    chk("t5_stat_hs", bus.m_axis_status_tvalid, 1'b1);
    @(negedge clk);
    bus.m_axis_status_tready = 1'b0;
    #1;
    chk("t5_idle_v", bus.m_axis_status_tvalid, 1'b0);
    chk("t5_idle_rdy", bus.s_axis_cmd_tready, 1'b1);

    // reset mid-drain with random data backpressure
    run_cmd(32'h5000, 64, 0, 0, 1, 40);
    chk("t6_aborted", aborted, 1'b1);
    @(negedge clk);
    idle_inputs();
    bus.m_axis_data_tready = 1'b1;
    rst = 1'b1;
    #1;
    chk("t6_cmd_rdy_r", bus.s_axis_cmd_tready, 1'b0);
    @(negedge clk);
    #1;
    chk("t6_arvalid", bus.m_axi_arvalid, 1'b0);
    chk("t6_rready", bus.m_axi_rready, 1'b0);
    chk("t6_stat_v", bus.m_axis_status_tvalid, 1'b0);
    chk("t6_dvalid", bus.m_axis_data_tvalid, 1'b0);
    rst = 1'b0;
    #1;
    chk("t6_cmd_rdy", bus.s_axis_cmd_tready, 1'b1);
    run_cmd(32'h6000, 8, 0, 0, 0, 0);
    chk("t6_a0", ar_a[0], 32'h6000); chk("t6_l0", ar_l[0], 7);
    chk("t6_beats", n_beats, 8);
    chk("t6_status", st, 18'h00008);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/axi_burst_reader.md
AXI_BURST_READER -- requirements
Module: axi_burst_reader

Interface
REQ-001 Parameter AXI_DWIDTH, default 128, data width in bits; power of two, 32..1024.
REQ-002 Parameter AXI_AWIDTH, default 32, address width.
REQ-003 Parameter AXI_IDWIDTH, default 1, ID width.
REQ-004 Parameter LEN_WIDTH, default 16, command length field width in beats.
REQ-005 Parameter MAX_BURST, default 16, maximum beats per AR burst; power of two, 1..256.
REQ-006 Parameter MAX_OUTSTANDING, default 4, maximum issued-but-incomplete bursts; 1..16.
REQ-007 The block SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.
REQ-008 clk  in  1  clock.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 m_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arregion/arqos/arvalid  out  AXI4 widths  read address channel.
REQ-011 m_axi_arready  in  1  AR accept.
REQ-012 m_axi_rid/rdata/rresp/rlast/rvalid  in  AXI4 widths  read data channel.
REQ-013 m_axi_rready  out  1  R accept.
REQ-014 s_axis_cmd_tvalid/tready  in/out  1  command handshake.
REQ-015 s_axis_cmd_tdata  in  LEN_WIDTH+AXI_AWIDTH  {len_beats, start_addr}.
REQ-016 m_axis_status_tvalid/tready  out/in  1  status handshake.
REQ-017 m_axis_status_tdata  out  LEN_WIDTH+2  {worst_resp[1:0], beats_received}.
REQ-018 m_axis_data_tdata/tkeep  out  AXI_DWIDTH, AXI_DWIDTH/8  read data; tkeep all ones.
REQ-019 m_axis_data_tlast/tvalid/tready  out/out/in  1  data stream framing and handshake.

Function
REQ-020 FSM states: IDLE, ADDR, DRAIN, STATUS.
REQ-021 s_axis_cmd_tready SHALL be 1 only in IDLE; handshake latches len and addr with address bits below log2(AXI_DWIDTH/8) forced to 0.
REQ-022 IDLE -> ADDR on handshake with len>0; IDLE -> STATUS on handshake with len=0 (no AR, no data, status {0,0}).
REQ-023 Burst beats = min(remaining, MAX_BURST, beats to next 4 KB boundary); arlen = beats-1.
REQ-024 Constants: arsize = log2(AXI_DWIDTH/8), arburst = INCR (01), arid = 0, arlock/arcache/arprot/arregion/arqos = 0.
REQ-025 araddr/arlen SHALL stay stable while arvalid=1 and arready=0.
REQ-026 Each AR handshake SHALL advance address by beats*AXI_DWIDTH/8 and subtract beats from remaining; ADDR -> DRAIN when remaining reaches 0.
REQ-027 arvalid SHALL be 0 while the outstanding count equals MAX_OUTSTANDING.
REQ-028 Outstanding count: +1 on AR handshake, -1 on R handshake with rlast, unchanged when both occur in one cycle.
REQ-029 R to data stream SHALL be combinational, zero latency: data tvalid = rvalid, tdata = rdata, rready = data tready, in ADDR and DRAIN only; rready = 0 in IDLE and STATUS.
REQ-030 m_axis_data_tlast = 1 only on the beat that brings beats_received to len; per-burst rlast SHALL NOT propagate otherwise.
REQ-031 worst_resp SHALL be the numeric maximum of all rresp in the command, cleared on command accept; transfer continues on error.
REQ-032 DRAIN -> STATUS on the cycle after the final beat handshake; status tvalid = 1 in STATUS, tdata held stable until tready.
REQ-033 STATUS -> IDLE on status handshake; the next command may be accepted in the following cycle.
REQ-034 An R beat arriving in IDLE/STATUS is not accepted (rready=0); its behaviour is not defined.

Reset
REQ-035 On rst: state IDLE, cmd tready 0 during reset and 1 the cycle after, arvalid 0, status tvalid 0, counters/address/worst_resp 0; rst mid-command SHALL abandon the command without status.

Verification
REQ-036 addr 0x1000, len 40, MAX_BURST 16, arready/tready always 1 -> AR lengths 15,15,7; 40 data beats; tlast only on beat 40; status {00,40}.
REQ-037 addr 0x0FC0, len 8, AXI_DWIDTH 128 -> two bursts, arlen 3 at 0x0FC0 then arlen 3 at 0x1000 (no 4 KB crossing).
REQ-038 len 100, arready 1, rvalid withheld -> exactly MAX_OUTSTANDING(4) ARs issued, then arvalid 0 until a rlast handshake.
REQ-039 len 16, rresp 2 (SLVERR) on beat 5 only -> all 16 beats delivered, status {10,16}.
REQ-040 len 0 -> no AR, no data; status {00,0} after 1 cycle; with status tready 0 for 5 cycles, tdata held stable and cmd tready stays 0.
REQ-041 rst asserted mid-DRAIN with random data tready backpressure -> outputs at reset values next cycle; new command completes normally.
